// File: rtl/cic3_dsf_dec_if.sv
// cic3_dsf_dec_if: sample-stream side of the CIC decimator (ratio select, input bits, PCM output)
interface cic3_dsf_dec_if;
  logic [1:0]  srat;
  logic [1:0]  din;
  logic [31:0] dout;
  modport master (output srat, output din, input dout);
  modport slave (input srat, input din, output dout);
endinterface

// File: rtl/cic3_dsf_dec.sv
// cic3_dsf_dec: third-order CIC decimator turning a 2-bit sigma-delta stream into 32-bit PCM every R cycles
module cic3_dsf_dec (
  input logic          clki,
  input logic          rst_n,
  input logic          clko,
  cic3_dsf_dec_if.slave bus
);
  logic [31:0] x, i1, i2, i3, d1, d2, d3, c1, c2, c3;
  logic [5:0]  cnt, rm1;
  logic [1:0]  srat_q;
  logic        flush, strobe;
  logic        unused_clko;
  assign unused_clko = clko;
  // Sign-extend input, decode R-1 from the registered ratio, detect ratio change, evaluate combs
  always_comb begin
    x      = {{30{bus.din[1]}}, bus.din};
    rm1    = 6'((7'd8 << srat_q) - 7'd1);
    flush  = bus.srat != srat_q;
    strobe = !flush && cnt == rm1;
    c1     = i3 - d1;
    c2     = c1 - d2;
    c3     = c2 - d3;
  end
  // Ratio register; a mismatch with the live select triggers the flush
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) srat_q <= 2'd0;
    else        srat_q <= bus.srat;
  // Integrator chain, running every cycle with modulo-2^32 wrap
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= flush ? '0 : i1 + x;
      i2 <= flush ? '0 : i2 + i1;
      i3 <= flush ? '0 : i3 + i2;
    end
  // Decimation counter; the flush cycle leaves it at 0 so the next cycle opens a fresh period
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= (flush || strobe) ? '0 : cnt + 6'd1;
  // Comb delays advance only on the strobe; flush clears them
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (flush) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (strobe) begin
      d1 <= i3;
      d2 <= c1;
      d3 <= c2;
    end
  // Output word updates on the strobe and holds otherwise, including through a flush
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n)      bus.dout <= '0;
    else if (strobe) bus.dout <= c3;
endmodule

// File: tb/tb_cic3_dsf_dec.sv
// tb_cic3_dsf_dec: scoreboard bench checking the CIC decimator against a closed-form binomial model
module tb_cic3_dsf_dec;
  logic clki = 1'b0, clko = 1'b0, rst_n = 1'b0;
  cic3_dsf_dec_if bus ();
  cic3_dsf_dec dut (.clki(clki), .rst_n(rst_n), .clko(clko), .bus(bus));
  always #5 clki = ~clki;
  always #7 clko = ~clko;

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [31:0] exp_q[$];
  longint xs[$];
  longint vs[$];
  logic [1:0]  sq_m = 2'd0;
  logic [31:0] dout_m = '0;

  function automatic longint hist(int k);
    return (vs.size() > k) ? vs[vs.size() - 1 - k] : 64'sd0;
  endfunction

  // Model: i3 seen at edge e weights sample j by C(e-1-j,2); output is the 3rd difference of those at strobes
  function automatic void model_edge(logic [1:0] d, logic [1:0] s);
    int e;
    longint v, a, y;
    if (s != sq_m) begin
      xs.delete();
      vs.delete();
      sq_m = s;
      return;
    end
    xs.push_back(longint'($signed(d)));
    e = xs.size();
    if (e % (8 << sq_m) != 0) return;
    v = 0;
    for (int j = 1; j <= e - 3; j++) begin
      a = longint'(e - 1 - j);
      v += xs[j-1] * ((a * (a - 1)) / 2);
    end
    vs.push_back(v);
    y = hist(0) - 3 * hist(1) + 3 * hist(2) - hist(3);
    dout_m = y[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  task automatic step(input logic [1:0] d, input logic [1:0] s, input logic r);
    @(negedge clki);
    bus.din  = d;
    bus.srat = s;
    if (!r) begin
      rst_n = 1'b0;
      xs.delete();
      vs.delete();
      sq_m   = 2'd0;
      dout_m = '0;
      #1 chk("reset_dout", bus.dout, 32'd0);
    end else begin
      rst_n = 1'b1;
      model_edge(d, s);
    end
    exp_q.push_back(dout_m);
  endtask

  task automatic run(input int n, input logic [1:0] d, input logic [1:0] s);
    for (int k = 0; k < n; k++) step(d, s, 1'b1);
  endtask

  // Monitor: one expected word per clock edge, compared just after the edge
  always @(posedge clki) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (bus.dout !== e) begin
        miscompares++;
        $display("FAIL dout cycle %0d: got %h expected %h", cyc, bus.dout, e);
      end
    end
  end

  initial begin
    bus.din  = 2'b00;
    bus.srat = 2'd0;
    for (int k = 0; k < 6; k++) step(k[0] ? 2'b01 : 2'b00, 2'd0, 1'b0);
    run(40, 2'b00, 2'd0);
    chk("idle_zero", bus.dout, 32'd0);
    run(200, 2'b01, 2'd0);
    chk("dc_r8", bus.dout, 32'd512);
    for (int k = 0; k < 3; k++) step(2'b01, 2'd0, 1'b0);
    run(120, 2'b01, 2'd0);
    chk("dc_r8_after_reset", bus.dout, 32'd512);
    for (int k = 0; k < 200; k++) step(k[0] ? 2'b11 : 2'b01, 2'd0, 1'b1);
    chk("alternating", bus.dout, 32'd0);
    run(40, 2'b00, 2'd1);
    step(2'b01, 2'd1, 1'b1);
    run(200, 2'b00, 2'd1);
    chk("impulse_tail", bus.dout, 32'd0);
    run(120, 2'b11, 2'd0);
    chk("switch_pre", bus.dout, 32'hFFFF_FE00);
    run(300, 2'b11, 2'd2);
    chk("switch_post", bus.dout, 32'hFFFF_8000);
    run(3000, 2'b10, 2'd3);
    chk("dc_r64_neg", bus.dout, 32'hFFF8_0000);
    for (int k = 0; k < 2; k++) step(2'b01, 2'd3, 1'b0);
    run(700, 2'b01, 2'd3);
    chk("release_flush_r64", bus.dout, 32'h0004_0000);
    for (int seg = 0; seg < 6; seg++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      for (int k = 0; k < 400; k++) step(2'($urandom), s, 1'b1);
    end
    repeat (2) @(posedge clki);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
